// File: rtl/pcie_phy_pkg.sv
// -----------------------------------------------------------------------------
// pcie_phy_pkg
// Shared definitions for the PCIe physical-layer receive datapath blocks:
// lane count, the unstriper output FSM state type, the legal contiguous lane
// masks, and the lane-select result type.
// No ports (package).
// -----------------------------------------------------------------------------
package pcie_phy_pkg;

    localparam int LANES = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,   // no byte held on the output
        ST_SEND = 1'b1    // a byte is held on the output
    } unstripe_state_t;

    // Legal masks form a run of set bits that starts at lane 0.
    localparam logic [LANES-1:0] MASK_1LANE = 4'b0001;
    localparam logic [LANES-1:0] MASK_2LANE = 4'b0011;
    localparam logic [LANES-1:0] MASK_3LANE = 4'b0111;
    localparam logic [LANES-1:0] MASK_4LANE = 4'b1111;

    // Result of a lane search: whether a set lane was found and its index.
    typedef struct packed {
        logic       found;
        logic [1:0] idx;
    } lane_sel_t;

    function automatic logic is_legal_mask(input logic [LANES-1:0] mask);
        return (mask == MASK_1LANE) || (mask == MASK_2LANE) ||
               (mask == MASK_3LANE) || (mask == MASK_4LANE);
    endfunction

endpackage

// File: rtl/byte_unstriping_4l_group_fifo.sv
// -----------------------------------------------------------------------------
// group_fifo
// Synchronous FIFO of DEPTH entries, DATA_W bits each, used to queue lane
// groups ({mask, lane3..lane0}) in front of the unstriper serializer.
// Exposes the head entry and the entry behind it so the consumer can move
// from one group to the next without a bubble.
//
// Ports:
//   clk           clock, all updates on posedge
//   rst_n         asynchronous active-low reset; clears pointers and count
//   i_push        write i_wdata (ignored when full)
//   i_wdata       entry to write
//   i_pop         drop the head entry (ignored when empty)
//   o_rdata       head entry
//   o_rdata_next  entry behind the head (valid when o_count >= 2)
//   o_full        count == DEPTH
//   o_empty       count == 0
//   o_count       number of stored entries, 0..DEPTH
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module group_fifo #(
    parameter int DATA_W = 36,
    parameter int DEPTH  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_push,
    input  logic [DATA_W-1:0]       i_wdata,
    input  logic                    i_pop,
    output logic [DATA_W-1:0]       o_rdata,
    output logic [DATA_W-1:0]       o_rdata_next,
    output logic                    o_full,
    output logic                    o_empty,
    output logic [$clog2(DEPTH):0]  o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic [AW-1:0]     w_rd_ptr_plus1;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_full   = (r_count == CW'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign o_count  = r_count;

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop  && !o_empty;

    assign w_rd_ptr_plus1 = r_rd_ptr + AW'(1);
    assign o_rdata        = r_mem[r_rd_ptr];
    assign o_rdata_next   = r_mem[w_rd_ptr_plus1];

    // NOTE: the storage array has no reset; only the pointers and count do,
    // and nothing reads an entry before it has been written.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= w_rd_ptr_plus1;
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

endmodule

// File: rtl/byte_unstriping_4l.sv
// -----------------------------------------------------------------------------
// byte_unstriping_4l
// Four-lane to single-byte unstriper for the PCIe PHY receive path. Lane
// groups (lane 0 earliest) are queued in a small group FIFO and the valid
// lanes are serialized in ascending lane order onto one byte stream with a
// valid/ready handshake. Invalid lanes are skipped.
//
// Ports:
//   clk         clock, all updates on posedge
//   reset       asynchronous active-low reset; clears all state
//   in0..in3    lane bytes, lane 0 first
//   lane_valid  per-lane qualifier; a group is offered when any bit is set
//   in_ready    group accepted on posedge with lane_valid != 0 && in_ready
//   data_out    serialized byte
//   valid_out   data_out holds a valid byte
//   out_ready   downstream takes the byte on posedge with valid_out
//   err_out     sticky non-contiguous-mask flag
//
// Build option: define UNSTRIPE_ERR_EN to drop non-contiguous masks (still
// handshaken) and raise err_out. Without it every non-zero mask is queued
// and err_out is tied 0.
// -----------------------------------------------------------------------------
module byte_unstriping_4l
    import pcie_phy_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   in0,
    input  logic [WIDTH-1:0]   in1,
    input  logic [WIDTH-1:0]   in2,
    input  logic [WIDTH-1:0]   in3,
    input  logic [LANES-1:0]   lane_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   data_out,
    output logic               valid_out,
    input  logic               out_ready,
    output logic               err_out
);

    localparam int ENTRY_W = WIDTH * LANES + LANES;
    localparam int CNT_W   = $clog2(DEPTH) + 1;

    // Lowest set lane of mask at or above lane index start (start may be 4).
    function automatic lane_sel_t find_lane(input logic [LANES-1:0] mask,
                                            input logic [2:0]       start);
        lane_sel_t sel;
        sel = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (mask[i] && (3'(i) >= start)) begin
                sel.found = 1'b1;
                sel.idx   = 2'(i);
            end
        end
        return sel;
    endfunction

    function automatic logic [WIDTH-1:0] lane_byte(input logic [ENTRY_W-1:0] entry,
                                                   input logic [1:0]         idx);
        return entry[int'(idx) * WIDTH +: WIDTH];
    endfunction

    function automatic logic [LANES-1:0] entry_mask(input logic [ENTRY_W-1:0] entry);
        return entry[ENTRY_W-1 -: LANES];
    endfunction

    // Registers
    unstripe_state_t  r_state;
    logic [1:0]       r_lane_ptr;
    logic [WIDTH-1:0] r_data_out;
    logic             r_valid_out;
    logic             r_in_ready;

    // Next-state and datapath wires
    unstripe_state_t  w_state_next;
    logic [1:0]       w_lane_ptr_next;
    logic [WIDTH-1:0] w_data_next;
    logic             w_valid_next;
    logic             w_pop;
    logic             w_push;
    logic             w_accept;
    logic [ENTRY_W-1:0] w_wdata;
    logic [ENTRY_W-1:0] w_head;
    logic [ENTRY_W-1:0] w_fifo_next;
    logic [ENTRY_W-1:0] w_next_entry;
    logic             w_next_avail;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [CNT_W-1:0] w_fifo_count;
    logic [CNT_W-1:0] w_count_next;
    lane_sel_t        w_head_low;
    lane_sel_t        w_head_above;
    lane_sel_t        w_next_low;

    // Input side
    assign w_wdata  = {lane_valid, in3, in2, in1, in0};
    assign w_accept = (lane_valid != '0) && r_in_ready && !w_fifo_full;

`ifdef UNSTRIPE_ERR_EN
    logic w_mask_legal;
    logic r_err;

    assign w_mask_legal = is_legal_mask(lane_valid);
    // An illegal group is handshaken so the upstream is not stalled, but dropped.
    assign w_push       = w_accept && w_mask_legal;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err <= 1'b0;
        end else if (w_accept && !w_mask_legal) begin
            r_err <= 1'b1;
        end
    end

    assign err_out = r_err;
`else
    assign w_push  = w_accept;
    assign err_out = 1'b0;
`endif

    group_fifo #(
        .DATA_W (ENTRY_W),
        .DEPTH  (DEPTH)
    ) u_group_fifo (
        .clk          (clk),
        .rst_n        (reset),
        .i_push       (w_push),
        .i_wdata      (w_wdata),
        .i_pop        (w_pop),
        .o_rdata      (w_head),
        .o_rdata_next (w_fifo_next),
        .o_full       (w_fifo_full),
        .o_empty      (w_fifo_empty),
        .o_count      (w_fifo_count)
    );

    // Lane selection. When the head is popped, the following group comes from
    // the FIFO if it already holds one, otherwise from a push in this same
    // cycle, so consecutive groups stream without a gap.
    assign w_next_avail = (w_fifo_count >= CNT_W'(2)) ||
                          (w_push && (w_fifo_count == CNT_W'(1)));
    assign w_next_entry = (w_fifo_count >= CNT_W'(2)) ? w_fifo_next : w_wdata;

    assign w_head_low   = find_lane(entry_mask(w_head), 3'd0);
    assign w_head_above = find_lane(entry_mask(w_head), {1'b0, r_lane_ptr} + 3'd1);
    assign w_next_low   = find_lane(entry_mask(w_next_entry), 3'd0);

    assign w_count_next = w_fifo_count + CNT_W'(w_push) - CNT_W'(w_pop);

    // State register
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_lane_ptr  <= '0;
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
            r_in_ready  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_lane_ptr  <= w_lane_ptr_next;
            r_data_out  <= w_data_next;
            r_valid_out <= w_valid_next;
            r_in_ready  <= (w_count_next != CNT_W'(DEPTH));
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves one unassigned and infers a latch.
        w_state_next    = r_state;
        w_lane_ptr_next = r_lane_ptr;
        w_data_next     = r_data_out;
        w_valid_next    = r_valid_out;
        w_pop           = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // Queued masks are never zero, so a lowest lane always exists.
                if (!w_fifo_empty) begin
                    w_lane_ptr_next = w_head_low.idx;
                    w_data_next     = lane_byte(w_head, w_head_low.idx);
                    w_valid_next    = 1'b1;
                    w_state_next    = ST_SEND;
                end
            end

            ST_SEND: begin
                if (out_ready) begin
                    if (w_head_above.found) begin
                        w_lane_ptr_next = w_head_above.idx;
                        w_data_next     = lane_byte(w_head, w_head_above.idx);
                    end else begin
                        w_pop = 1'b1;
                        if (w_next_avail) begin
                            w_lane_ptr_next = w_next_low.idx;
                            w_data_next     = lane_byte(w_next_entry, w_next_low.idx);
                        end else begin
                            w_lane_ptr_next = '0;
                            w_valid_next    = 1'b0;
                            w_state_next    = ST_IDLE;
                        end
                    end
                end
            end

            default: begin
                w_state_next = ST_IDLE;
                w_valid_next = 1'b0;
            end
        endcase
    end

    // Outputs
    always_comb begin
        in_ready  = r_in_ready;
        data_out  = r_data_out;
        valid_out = r_valid_out;
    end

endmodule

// File: tb/tb_byte_unstriping_4l.sv
// -----------------------------------------------------------------------------
// tb_byte_unstriping_4l
// Self-checking bench for byte_unstriping_4l. Expected bytes are queued when a
// group is accepted and compared in order as the DUT hands them downstream.
// Honors UNSTRIPE_ERR_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_byte_unstriping_4l;

    logic       clk;
    logic       reset;
    logic [7:0] in0, in1, in2, in3;
    logic [3:0] lane_valid;
    logic       in_ready;
    logic [7:0] data_out;
    logic       valid_out;
    logic       out_ready;
    logic       err_out;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_q [$];

    byte_unstriping_4l #(
        .WIDTH (8),
        .DEPTH (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in0        (in0),
        .in1        (in1),
        .in2        (in2),
        .in3        (in3),
        .lane_valid (lane_valid),
        .in_ready   (in_ready),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .out_ready  (out_ready),
        .err_out    (err_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic bit mask_queued(input logic [3:0] mask);
`ifdef UNSTRIPE_ERR_EN
        return (mask == 4'b0001) || (mask == 4'b0011) ||
               (mask == 4'b0111) || (mask == 4'b1111);
`else
        return mask != 4'b0000;
`endif
    endfunction

    // Offer a group until accepted; returns 1 time unit after the accepting edge.
    task automatic send_group(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3,
                              input logic [3:0] mask);
        logic [7:0] bytes [4];
        bit done;
        done = 1'b0;
        bytes[0] = b0; bytes[1] = b1; bytes[2] = b2; bytes[3] = b3;
        in0 = b0; in1 = b1; in2 = b2; in3 = b3;
        lane_valid = mask;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                done = 1'b1;
                if (mask_queued(mask)) begin
                    for (int i = 0; i < 4; i++) begin
                        if (mask[i]) exp_q.push_back(bytes[i]);
                    end
                end
            end
            @(posedge clk); #1;
        end
        lane_valid = 4'b0000;
        if (!done) check("accept_timeout", 32'd0, 32'd1);
    endtask

    // Wait until every expected byte has been delivered and the output is idle.
    task automatic wait_drain();
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !valid_out) break;
        end
        check("drain_left", exp_q.size(), 32'd0);
        @(posedge clk); #1;
    endtask

    // Output monitor: a byte is taken on the next posedge when valid && ready.
    initial begin
        forever begin
            @(negedge clk);
            if (valid_out && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_byte", {31'd0, valid_out}, 32'd0);
                end else begin
                    check("out_byte", {24'd0, data_out}, {24'd0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int run;

        // Reset held with a group offered: nothing accepted, outputs cleared.
        reset = 1'b0; out_ready = 1'b1; lane_valid = 4'b1111;
        in0 = 8'hF0; in1 = 8'hF1; in2 = 8'hF2; in3 = 8'hF3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_in_ready",  {31'd0, in_ready},  32'd0);
            check("rst_valid_out", {31'd0, valid_out}, 32'd0);
            check("rst_data_out",  {24'd0, data_out},  32'd0);
            check("rst_err_out",   {31'd0, err_out},   32'd0);
        end
        @(posedge clk); #1;
        lane_valid = 4'b0000;
        reset = 1'b1;
        @(negedge clk);
        check("rst_nothing_out", {31'd0, valid_out}, 32'd0);
        @(posedge clk); #1;

        // Single full group: first byte one cycle after the accepting edge.
        send_group(8'h11, 8'h22, 8'h33, 8'h44, 4'b1111);
        @(negedge clk);
        check("lat_not_yet", {31'd0, valid_out}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("lat_first_valid", {31'd0, valid_out}, 32'd1);
        check("lat_first_data",  {24'd0, data_out},  32'h11);
        @(posedge clk); #1;
        wait_drain();

        // Back-to-back groups: 8 contiguous bytes, no bubble.
        send_group(8'hA0, 8'hA1, 8'hA2, 8'hA3, 4'b1111);
        send_group(8'hB0, 8'hB1, 8'hB2, 8'hB3, 4'b1111);
        run = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (valid_out) run++;
        end
        check("b2b_run", run, 32'd8);
        @(negedge clk);
        check("b2b_end", {31'd0, valid_out}, 32'd0);
        @(posedge clk); #1;
        wait_drain();

        // Backpressure: FIFO fills after two groups, first byte held.
        out_ready = 1'b0;
        send_group(8'hC0, 8'hC1, 8'hC2, 8'hC3, 4'b1111);
        send_group(8'hD0, 8'hD1, 8'hD2, 8'hD3, 4'b1111);
        in0 = 8'hE0; in1 = 8'hE1; in2 = 8'hE2; in3 = 8'hE3;
        lane_valid = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_in_ready",  {31'd0, in_ready},  32'd0);
            check("bp_valid_out", {31'd0, valid_out}, 32'd1);
            check("bp_hold_data", {24'd0, data_out},  32'hC0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send_group(8'hE0, 8'hE1, 8'hE2, 8'hE3, 4'b1111);
        wait_drain();

        // Partial mask 0011 followed by a full group.
        send_group(8'hAA, 8'hBB, 8'hEE, 8'hFF, 4'b0011);
        send_group(8'h51, 8'h52, 8'h53, 8'h54, 4'b1111);
        wait_drain();

        // Non-contiguous mask 0101.
        send_group(8'h5A, 8'h99, 8'hC3, 8'h77, 4'b0101);
        @(negedge clk);
`ifdef UNSTRIPE_ERR_EN
        check("gap_err_set", {31'd0, err_out}, 32'd1);
`else
        check("gap_err_clear", {31'd0, err_out}, 32'd0);
`endif
        @(posedge clk); #1;
        wait_drain();
        @(negedge clk);
`ifdef UNSTRIPE_ERR_EN
        check("gap_err_sticky", {31'd0, err_out}, 32'd1);
`else
        check("gap_err_stays0", {31'd0, err_out}, 32'd0);
`endif
        @(posedge clk); #1;

        // Reset mid-group flushes the held byte and queued groups.
        out_ready = 1'b0;
        send_group(8'h61, 8'h62, 8'h63, 8'h64, 4'b1111);
        send_group(8'h65, 8'h66, 8'h00, 8'h00, 4'b0011);
        @(negedge clk);
        check("mid_held_valid", {31'd0, valid_out}, 32'd1);
        check("mid_held_data",  {24'd0, data_out},  32'h61);
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("mid_rst_valid",    {31'd0, valid_out}, 32'd0);
            check("mid_rst_in_ready", {31'd0, in_ready},  32'd0);
            check("mid_rst_data",     {24'd0, data_out},  32'd0);
            check("mid_rst_err",      {31'd0, err_out},   32'd0);
            @(posedge clk); #1;
        end
        reset = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_rst_idle", {31'd0, valid_out}, 32'd0);
            @(posedge clk); #1;
        end
        send_group(8'h71, 8'h72, 8'h73, 8'h74, 4'b1111);
        wait_drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
